// File: rtl/conv3x3_engine_if.sv
// conv3x3_engine_if
//   Handshake/data bundle for conv3x3_engine.
//   master : window producer / result consumer / coefficient writer
//   slave  : the convolution engine
//   Signals:
//     in_valid/in_ready    window handshake
//     mode                 kernel slot select, sampled with the window
//     pixel_0..pixel_8     3x3 window, row-major, pixel_4 = centre
//     out_valid/out_ready  result handshake
//     conv_out             result pixel
//     coef_we/addr/wdata   kernel bank write port, addr = {slot, index}
interface conv3x3_engine_if #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int COEF_WIDTH    = 5,
  parameter int KERNEL_SLOTS  = 4,
  parameter int SHIFT_WIDTH   = 4
);
  localparam int SLOT_W  = $clog2(KERNEL_SLOTS);
  localparam int WDATA_W = (COEF_WIDTH > SHIFT_WIDTH) ? COEF_WIDTH : SHIFT_WIDTH;

  logic                     in_valid;
  logic                     in_ready;
  logic [SLOT_W-1:0]        mode;
  logic [BIT_PER_PIXEL-1:0] pixel_0, pixel_1, pixel_2;
  logic [BIT_PER_PIXEL-1:0] pixel_3, pixel_4, pixel_5;
  logic [BIT_PER_PIXEL-1:0] pixel_6, pixel_7, pixel_8;
  logic                     out_valid;
  logic                     out_ready;
  logic [BIT_PER_PIXEL-1:0] conv_out;
  logic                     coef_we;
  logic [SLOT_W+3:0]        coef_addr;
  logic [WDATA_W-1:0]       coef_wdata;

  modport master (
    output in_valid, mode, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, out_ready,
           coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, conv_out
  );

  modport slave (
    input  in_valid, mode, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, out_ready,
           coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, conv_out
  );
endinterface

// File: rtl/conv3x3_engine.sv
// conv3x3_engine
//   3-stage pipelined 3x3 convolution with a runtime-programmable bank of
//   KERNEL_SLOTS signed kernels, each with its own rounding right-shift.
//   Result is rounded and saturated to BIT_PER_PIXEL unsigned.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    conv3x3_engine_if.slave (window in, result out, bank write)
//   Build option:
//     CONV3X3_ABS_EN  when defined, S3 saturates |result| (edge magnitude)
//                     instead of clamping negatives to 0.
`default_nettype none

module conv3x3_engine #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int COEF_WIDTH    = 5,
  parameter int KERNEL_SLOTS  = 4,
  parameter int SHIFT_WIDTH   = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  conv3x3_engine_if.slave    bus
);
  localparam int SLOT_W = $clog2(KERNEL_SLOTS);
  localparam int STAGES = 3;
  localparam int PROD_W = BIT_PER_PIXEL + COEF_WIDTH + 1;
  localparam int ACC_W  = BIT_PER_PIXEL + COEF_WIDTH + 5;
  localparam int NTAP   = 9;

  // Reset contents of the kernel bank.
  function automatic logic signed [COEF_WIDTH-1:0] f_def_coef(int s, int k);
    int v;
    case (s)
      0:       v = (k == 4) ? -4  : ((k % 2) == 1) ? 1 : 0;
      1:       v = (k == 4) ? -12 : ((k % 2) == 1) ? 2 : 1;
      2:       v = (k == 4) ? 1   : 0;
      3:       v = (k == 4) ? 4   : ((k % 2) == 1) ? 2 : 1;
      default: v = 0;
    endcase
    return COEF_WIDTH'(v);
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] f_def_shift(int s);
    return (s == 3) ? SHIFT_WIDTH'(4) : '0;
  endfunction

  // Handshake: the whole pipe moves as one; a stalled output freezes everything.
  logic w_advance;
  assign w_advance    = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = w_advance;

  logic [BIT_PER_PIXEL-1:0] w_pix [NTAP];
  assign w_pix[0] = bus.pixel_0;
  assign w_pix[1] = bus.pixel_1;
  assign w_pix[2] = bus.pixel_2;
  assign w_pix[3] = bus.pixel_3;
  assign w_pix[4] = bus.pixel_4;
  assign w_pix[5] = bus.pixel_5;
  assign w_pix[6] = bus.pixel_6;
  assign w_pix[7] = bus.pixel_7;
  assign w_pix[8] = bus.pixel_8;

  // ---------------- kernel bank ----------------
  logic signed [COEF_WIDTH-1:0]  r_coef  [KERNEL_SLOTS][NTAP];
  logic        [SHIFT_WIDTH-1:0] r_shift [KERNEL_SLOTS];
  logic [SLOT_W-1:0] w_wr_slot;
  logic [3:0]        w_wr_idx;
  assign w_wr_slot = bus.coef_addr[SLOT_W+3:4];
  assign w_wr_idx  = bus.coef_addr[3:0];

  // Writes are independent of the pipeline stall. S1 reads the register
  // before this edge, so a same-cycle accept sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < KERNEL_SLOTS; s++) begin
        for (int k = 0; k < NTAP; k++) r_coef[s][k] <= f_def_coef(s, k);
        r_shift[s] <= f_def_shift(s);
      end
    end else if (bus.coef_we) begin
      if (w_wr_idx < 4'd9)
        r_coef[w_wr_slot][w_wr_idx] <= bus.coef_wdata[COEF_WIDTH-1:0];
      else if (w_wr_idx == 4'd9)
        r_shift[w_wr_slot] <= bus.coef_wdata[SHIFT_WIDTH-1:0];
    end
  end

  // ---------------- valid shift register ----------------
  logic [STAGES:1] r_vld_pipe;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_vld_pipe <= '0;
    else if (w_advance) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // ---------------- S1: products ----------------
  logic signed [PROD_W-1:0]      w_prod [NTAP];
  logic signed [PROD_W-1:0]      r_s1_prod [NTAP];
  logic        [SHIFT_WIDTH-1:0] r_s1_shift;

  // Pixel is zero-extended to make it a non-negative signed operand.
  for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
    assign w_prod[gi] = PROD_W'($signed({1'b0, w_pix[gi]})) *
                        PROD_W'(r_coef[bus.mode][gi]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAP; k++) r_s1_prod[k] <= '0;
      r_s1_shift <= '0;
    end else if (w_advance) begin
      for (int k = 0; k < NTAP; k++) r_s1_prod[k] <= w_prod[k];
      r_s1_shift <= r_shift[bus.mode];
    end
  end

  // ---------------- S2: adder tree ----------------
  logic signed [ACC_W-1:0]       w_sum;
  logic signed [ACC_W-1:0]       r_s2_acc;
  logic        [SHIFT_WIDTH-1:0] r_s2_shift;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAP; k++) w_sum = w_sum + ACC_W'(r_s1_prod[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_acc   <= '0;
      r_s2_shift <= '0;
    end else if (w_advance) begin
      r_s2_acc   <= w_sum;
      r_s2_shift <= r_s1_shift;
    end
  end

  // ---------------- S3: round, shift, saturate ----------------
  // One extra bit of headroom so the rounding add can never wrap.
  logic signed [ACC_W:0]          w_acc_x, w_half, w_rnd, w_shr, w_mag;
  logic        [BIT_PER_PIXEL-1:0] w_sat;
  logic        [BIT_PER_PIXEL-1:0] r_conv;

  always_comb begin
    w_acc_x = {r_s2_acc[ACC_W-1], r_s2_acc};
    w_half  = '0;
    if (r_s2_shift != '0) w_half[r_s2_shift - 1'b1] = 1'b1;
    w_rnd   = w_acc_x + w_half;
    w_shr   = w_rnd >>> r_s2_shift;
`ifdef CONV3X3_ABS_EN
    w_mag   = w_shr[ACC_W] ? -w_shr : w_shr;
`else
    w_mag   = w_shr;
`endif
    if (w_mag[ACC_W])                          w_sat = '0;
    else if (w_mag[ACC_W-1:BIT_PER_PIXEL] != '0) w_sat = '1;
    else                                       w_sat = w_mag[BIT_PER_PIXEL-1:0];
  end

  // Only real results update the output, so an empty pipe keeps the last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           r_conv <= '0;
    else if (w_advance && r_vld_pipe[2])  r_conv <= w_sat;
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.conv_out  = r_conv;

endmodule

`default_nettype wire

// File: doc/conv3x3_engine.md
Name: conv3x3_engine

Overview:
- Pipelined 3x3 convolution engine for the image filter datapath. It is the parametrised successor of the fixed two-mode Laplacian convolver.
- Kernel coefficients are signed and runtime-programmable, held in a bank of KERNEL_SLOTS selectable kernels, each with its own normalisation shift.
- Output is rounded and saturated.
- Valid/ready handshake on input and output, with full backpressure. Sits between the line-buffer window generator and the pixel output stage.

Parameters:
- BIT_PER_PIXEL, 8, unsigned pixel width in and out.
- COEF_WIDTH, 5, signed two's-complement coefficient width.
- KERNEL_SLOTS, 4, number of selectable kernels (power of 2, >=4).
- SHIFT_WIDTH, 4, width of the per-slot right-shift normaliser.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  window valid.
- in_ready  out  1  engine accepts the window this cycle.
- mode  in  log2(KERNEL_SLOTS)  kernel slot select; sampled with the window.
- pixel_0..pixel_8  in  BIT_PER_PIXEL each  3x3 window, row-major, pixel_4 = centre.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- conv_out  out  BIT_PER_PIXEL  result pixel.
- coef_we  in  1  coefficient/shift write strobe.
- coef_addr  in  log2(KERNEL_SLOTS)+4  {slot, index}; index 0-8 = coefficient k0-k8, index 9 = shift, 10-15 ignored.
- coef_wdata  in  max(COEF_WIDTH,SHIFT_WIDTH)  write data; low bits used.

Behaviour:
- Handshake: advance = out_ready | ~out_valid; in_ready = advance.
  - A window transfers when in_valid & in_ready.
  - All pipeline registers hold when advance = 0.
  - out_valid and conv_out stay stable until out_ready.
- Pipeline, 3 stages; latency 3 cycles from accept to out_valid when unstalled; throughput 1 result/cycle.
  - S1: capture the nine signed products p_i = {0,pixel_i} * k_i from the selected slot. Also capture the slot's shift and a valid bit.
  - S2: signed adder tree, ACC_W = BIT_PER_PIXEL+COEF_WIDTH+5 bits. Never overflows.
  - S3: if shift > 0, add 2^(shift-1) and arithmetic-shift right by shift. Then clamp: negative -> 0; > 2^BIT_PER_PIXEL-1 -> all ones; otherwise the value.
- Coefficient and slot selection:
  - Coefficients and shift are taken at the S1 capture of each window.
  - A write on cycle N affects windows accepted on cycle N+1 onward. Windows already in flight are unaffected.
  - Simultaneous write and accept to the same slot: the accepted window uses the old value.
  - Writes are accepted regardless of stall. Writes to index 10-15 do nothing.
- Reset values of the kernel bank:
  - Slot 0: 0,1,0,1,-4,1,0,1,0, shift 0.
  - Slot 1: 1,2,1,2,-12,2,1,2,1, shift 0.
  - Slot 2: identity (k4 = 1, others 0), shift 0.
  - Slot 3: Gaussian 1,2,1,2,4,2,1,2,1, shift 4.
  - Slots >= 4: all zero, shift 0.
- Reset of outputs and pipeline: out_valid = 0, conv_out = 0, all stage valid bits = 0. in_ready = 1 after reset release.
- Reset asserted mid-operation: in-flight windows are discarded, not output. The bank returns to the defaults above.
- Empty pipeline: out_valid = 0. conv_out holds its last value, or 0 after reset.

Optional Feature:
- Macro: CONV3X3_ABS_EN.
- Defined: S3 takes the absolute value of the shifted result before saturating. For example, -40 -> 40 and -360 -> 255. Used for edge-magnitude output.
- Undefined: negative results clamp to 0 as above.

Test Plan:
- Slot 0, centre 10, neighbours 20, corners 0, out_ready = 1 -> conv_out = 40 with out_valid exactly 3 cycles after accept.
- Slot 0, centre 50, four neighbours 40 -> 0 without the macro; 40 with CONV3X3_ABS_EN.
- Slot 1, all pixels 255 except centre 0 -> sum 3060 -> 255. Slot 3, all pixels 100 -> 100. Slot 3, centre 2, others 0 -> 1 (rounding). Slot 3, centre 1, others 0 -> 0.
- Backpressure:
  - Stimulus: stream 6 windows with in_valid held high; out_ready low for cycles 2-7.
  - Required response: in_ready drops once 3 windows are in flight; conv_out stays stable while stalled; all 6 results arrive in order with no loss or duplication.
- Coefficient writes:
  - Stimulus: write slot 2 k4 = 3 on the same cycle a window with centre 20 is accepted; accept a second window with centre 20 on the next cycle.
  - Required response: first result 20, second result 60.
  - Also write shift 1 to slot 2 -> centre 21 yields 32 (63 plus rounding, shifted right by 1).
- Reset mid-operation:
  - Stimulus: assert reset with 2 windows in flight.
  - Required response: out_valid = 0 immediately; no stale result after release; slot 2 k4 is back to 1.
